retire_unit: RTL and testbench

Consumer end of the ROB commit interface. Takes up to DISPATCH_WIDTH committed instructions per cycle in program order and keeps the retirement RAT (architectural to physical map) up to date. Returns superseded physical registers to the rename free list through a buffered queue. On a branch mispredict it produces a one-cycle redirect pulse to fetch and exports the retirement RAT snapshot for front-end RAT recovery.

---
 rtl/retire_unit_pkg.sv | 30 +++
 rtl/retire_unit_free_reg_queue.sv | 66 ++++++
 rtl/retire_unit.sv | 96 +++++++++
 tb/tb_retire_unit.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/retire_unit_pkg.sv
// Shared types and sizing for the retire unit and its free-register queue.
// The optional instret counter is selected with INSTRET_COUNTER_EN (see retire_unit.sv).
package retire_unit_pkg;

    localparam int DISPATCH_WIDTH       = 2;
    localparam int PHYS_REGS_ADDR_WIDTH = 6;
    localparam int ARCH_REGS            = 32;
    localparam int FREE_Q_DEPTH         = 64;
    localparam int FREE_Q_ADDR_WIDTH    = $clog2(FREE_Q_DEPTH);

    typedef logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_reg_t;

    typedef struct packed {
        logic        en;
        phys_reg_t   phys_rd;
        logic [4:0]  arch_rd;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        is_branch_instr;
        logic        branch_correct;
        logic        branch_taken;
        logic [12:0] br_offset;
    } rob_commit_t;

    // Correct fall-through or taken target of a committed branch, 32-bit wrap.
    function automatic logic [31:0] branch_target(input rob_commit_t c);
        return c.pc + (c.branch_taken ? {{19{c.br_offset[12]}}, c.br_offset} : 32'd4);
    endfunction

endpackage

// File: rtl/retire_unit_free_reg_queue.sv
// Two-push / two-pop circular FIFO of freed physical registers with a
// saturating count and a sticky overflow flag for dropped pushes.
module free_reg_queue
    import retire_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            push_valid,
    input  phys_reg_t [1:0]       push_data,
    input  logic                  pop_ready,
    output logic [1:0]            out_valid,
    output phys_reg_t [1:0]       out_data,
    output logic                  overflow
);

    localparam int CW = FREE_Q_ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH = CW'(FREE_Q_DEPTH);
    localparam logic [FREE_Q_ADDR_WIDTH-1:0] PTR_ONE = FREE_Q_ADDR_WIDTH'(1);

    phys_reg_t                    mem [FREE_Q_DEPTH];
    logic [FREE_Q_ADDR_WIDTH-1:0] rd_ptr;
    logic [FREE_Q_ADDR_WIDTH-1:0] wr_ptr;
    logic [CW-1:0]                count;
    logic [CW-1:0]                count_after_pop;
    logic [CW-1:0]                space;
    logic [1:0]                   pop_n;
    logic [1:0]                   n_req;
    logic [1:0]                   n_acc;
    logic                         drop;
    phys_reg_t                    first_data;

    always_comb begin
        out_valid       = {count >= CW'(2), count >= CW'(1)};
        out_data[0]     = out_valid[0] ? mem[rd_ptr] : '0;
        out_data[1]     = out_valid[1] ? mem[rd_ptr + PTR_ONE] : '0;
        pop_n           = '0;
        if (pop_ready) pop_n = out_valid[1] ? 2'd2 : {1'b0, out_valid[0]};
        count_after_pop = count - CW'(pop_n);
        // Pushes are compacted so a lone lane-1 push lands in the next free slot.
        n_req           = {1'b0, push_valid[0]} + {1'b0, push_valid[1]};
        first_data      = push_valid[0] ? push_data[0] : push_data[1];
        space           = DEPTH - count_after_pop;
        n_acc           = (space >= CW'(n_req)) ? n_req : space[1:0];
        drop            = (n_acc != n_req);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            rd_ptr <= rd_ptr + FREE_Q_ADDR_WIDTH'(pop_n);
            wr_ptr <= wr_ptr + FREE_Q_ADDR_WIDTH'(n_acc);
            count  <= count_after_pop + CW'(n_acc);
            if (drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (n_acc != 2'd0) mem[wr_ptr] <= first_data;
        if (n_acc == 2'd2) mem[wr_ptr + PTR_ONE] <= push_data[1];
    end

endmodule

// File: rtl/retire_unit.sv
// Commit consumer: maintains the retirement RAT, frees superseded registers,
// raises mispredict redirects. Define INSTRET_COUNTER_EN to build the instret counter.
module retire_unit
    import retire_unit_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst_n,
    input  rob_commit_t [DISPATCH_WIDTH-1:0]    commit_if,
    output logic [DISPATCH_WIDTH-1:0]           free_valid,
    output phys_reg_t [DISPATCH_WIDTH-1:0]      free_phys,
    input  logic                                free_ready,
    output logic                                redirect_valid,
    output logic [31:0]                         redirect_pc,
    output phys_reg_t [ARCH_REGS-1:0]           rrat,
    output logic [63:0]                         instret,
    output logic                                free_q_overflow
);

    rob_commit_t                c0;
    rob_commit_t                c1;
    logic                       mispredict0;
    logic                       mispredict1;
    logic                       retire0;
    logic                       retire1;
    logic                       wr0;
    logic                       wr1;
    logic [1:0]                 push_valid;
    phys_reg_t [1:0]            push_data;
    phys_reg_t [ARCH_REGS-1:0]  rrat_d;
    logic                       unused_instr;

    assign c0           = commit_if[0];
    assign c1           = commit_if[1];
    assign unused_instr = ^{c0.instr, c1.instr};

    always_comb begin
        mispredict0 = c0.en & c0.is_branch_instr & ~c0.branch_correct;
        retire0     = c0.en;
        retire1     = c1.en & ~mispredict0;
        mispredict1 = retire1 & c1.is_branch_instr & ~c1.branch_correct;
        wr0         = retire0 && (c0.arch_rd != 5'd0);
        wr1         = retire1 && (c1.arch_rd != 5'd0);
        push_valid  = {c1.en && (c1.arch_rd != 5'd0), wr0};
        push_data[0] = rrat[c0.arch_rd];
        // A discarded lane returns its own register; a same-rd pair frees lane 0's.
        if (!retire1)
            push_data[1] = c1.phys_rd;
        else if (wr0 && (c0.arch_rd == c1.arch_rd))
            push_data[1] = c0.phys_rd;
        else
            push_data[1] = rrat[c1.arch_rd];
        rrat_d = rrat;
        if (wr0) rrat_d[c0.arch_rd] = c0.phys_rd;
        if (wr1) rrat_d[c1.arch_rd] = c1.phys_rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            for (int i = 0; i < ARCH_REGS; i++) rrat[i] <= PHYS_REGS_ADDR_WIDTH'(i);
        end else begin
            redirect_valid <= mispredict0 | mispredict1;
            if (mispredict0)
                redirect_pc <= branch_target(c0);
            else if (mispredict1)
                redirect_pc <= branch_target(c1);
            rrat <= rrat_d;
        end
    end

`ifdef INSTRET_COUNTER_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) instret_q <= '0;
        else        instret_q <= instret_q + 64'(retire0) + 64'(retire1);
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

    free_reg_queue u_free_q (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push_valid),
        .push_data  (push_data),
        .pop_ready  (free_ready),
        .out_valid  (free_valid),
        .out_data   (free_phys),
        .overflow   (free_q_overflow)
    );

endmodule

// File: tb/tb_retire_unit.sv
// Bench for retire_unit: directed commit scenarios plus random traffic,
// checked by a queue-based reference model and an independent monitor.
module tb_retire_unit;
    import retire_unit_pkg::*;

`ifdef INSTRET_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    rob_commit_t [1:0]     commit_if;
    logic [1:0]            free_valid;
    phys_reg_t [1:0]       free_phys;
    logic                  free_ready;
    logic                  redirect_valid;
    logic [31:0]           redirect_pc;
    phys_reg_t [31:0]      rrat;
    logic [63:0]           instret;
    logic                  free_q_overflow;

    retire_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .commit_if       (commit_if),
        .free_valid      (free_valid),
        .free_phys       (free_phys),
        .free_ready      (free_ready),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .rrat            (rrat),
        .instret         (instret),
        .free_q_overflow (free_q_overflow)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic        redir;
        logic [31:0] pc;
        logic [191:0] rrat;
        logic [63:0] instret;
        logic        ovf;
    } exp_t;

    logic [5:0]  m_rrat [32];
    logic [5:0]  m_free [$];
    exp_t        exp_q [$];
    logic        m_ovf;
    logic [63:0] m_instret;
    int          pend_n;
    int          pend_cyc;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [191:0] pack_rrat();
        logic [191:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) v[i*6 +: 6] = m_rrat[i];
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_rrat[i] = 6'(i);
        m_free.delete();
        exp_q.delete();
        m_ovf     = 1'b0;
        m_instret = '0;
        pend_n    = 0;
        pend_cyc  = -1;
    endfunction

    function automatic void push_free(input logic [5:0] v, inout int room);
        if (room > 0) begin
            m_free.push_back(v);
            room--;
            pend_n++;
        end else begin
            m_ovf = 1'b1;
        end
    endfunction

    function automatic rob_commit_t lane(input logic en, input int arch, input int phys,
                                         input logic [31:0] pc, input logic br,
                                         input logic corr, input logic taken,
                                         input logic [12:0] off);
        rob_commit_t c;
        c                 = '0;
        c.en              = en;
        c.arch_rd         = 5'(arch);
        c.phys_rd         = PHYS_REGS_ADDR_WIDTH'(phys);
        c.pc              = pc;
        c.instr           = $urandom;
        c.is_branch_instr = br;
        c.branch_correct  = corr;
        c.branch_taken    = taken;
        c.br_offset       = off;
        return c;
    endfunction

    function automatic rob_commit_t rand_lane();
        int arch;
        arch = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
        return lane($urandom_range(0, 4) != 0, arch, $urandom_range(0, 63),
                    $urandom & 32'hFFFF_FFFC, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    13'($urandom));
    endfunction

    // ---------------- driver ----------------
    // Applies one commit cycle at posedge+1, updates the model, returns at next posedge+1.
    task automatic drive(input rob_commit_t l0, input rob_commit_t l1, input logic rdy);
        exp_t        e;
        rob_commit_t l;
        int          room;
        int          vis;
        int          off;
        bit          discard;
        int          retired;
        commit_if[0] = l0;
        commit_if[1] = l1;
        free_ready   = rdy;
        vis          = m_free.size();
        room         = FREE_Q_DEPTH - (vis - (rdy ? ((vis >= 2) ? 2 : vis) : 0));
        discard      = 1'b0;
        retired      = 0;
        pend_n       = 0;
        e.redir      = 1'b0;
        e.pc         = '0;
        for (int w = 0; w < 2; w++) begin
            l = (w == 0) ? l0 : l1;
            if (!l.en) continue;
            if (discard) begin
                if (l.arch_rd != 0) push_free(l.phys_rd, room);
                continue;
            end
            if (l.arch_rd != 0) begin
                push_free(m_rrat[l.arch_rd], room);
                m_rrat[l.arch_rd] = l.phys_rd;
            end
            retired++;
            if (l.is_branch_instr && !l.branch_correct) begin
                discard = 1'b1;
                off     = l.br_offset[12] ? int'(l.br_offset) - 8192 : int'(l.br_offset);
                e.redir = 1'b1;
                e.pc    = l.pc + (l.branch_taken ? 32'(off) : 32'd4);
            end
        end
        m_instret += 64'(retired);
        pend_cyc  = cyc;
        e.due     = cyc + 1;
        e.rrat    = pack_rrat();
        e.instret = CNT_EN ? m_instret : 64'd0;
        e.ovf     = m_ovf;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(lane(0, 0, 0, 0, 0, 0, 0, 0), lane(0, 0, 0, 0, 0, 0, 0, 0), rdy);
    endtask

    // ---------------- monitor / scoreboard ----------------
    int   mon_vis;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst_n) begin
            mon_vis = m_free.size() - ((pend_cyc == cyc) ? pend_n : 0);
            check("free_valid", free_valid, {mon_vis >= 2, mon_vis >= 1});
            for (int k = 0; k < 2; k++)
                if (k < mon_vis) check("free_phys", free_phys[k], m_free[k]);
            if (free_ready)
                for (int k = 0; k < 2; k++)
                    if (k < mon_vis) void'(m_free.pop_front());
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                mon_e = exp_q.pop_front();
                check("redirect_valid", redirect_valid, mon_e.redir);
                if (mon_e.redir) check("redirect_pc", redirect_pc, mon_e.pc);
                check("rrat", rrat, mon_e.rrat);
                check("instret", instret, mon_e.instret);
                check("free_q_overflow", free_q_overflow, mon_e.ovf);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [5:0] first_freed;

    initial begin
        rst_n      = 1'b0;
        free_ready = 1'b0;
        commit_if  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rrat5", rrat[5], 6'd5);
        check("reset_rrat_all", rrat, pack_rrat());
        check("reset_free_valid", free_valid, 2'b00);
        check("reset_free_phys", free_phys, 12'd0);
        check("reset_instret", instret, 64'd0);
        check("reset_redirect_valid", redirect_valid, 1'b0);
        check("reset_redirect_pc", redirect_pc, 32'd0);
        check("reset_overflow", free_q_overflow, 1'b0);
        rst_n = 1'b1;

        // Dual retire, distinct destinations
        drive(lane(1, 3, 40, 32'h10, 0, 1, 0, 0), lane(1, 4, 41, 32'h14, 0, 1, 0, 0), 1'b1);
        check("dual_rrat3", rrat[3], 6'd40);
        check("dual_rrat4", rrat[4], 6'd41);
        check("dual_free_valid", free_valid, 2'b11);
        check("dual_free0", free_phys[0], 6'd3);
        check("dual_free1", free_phys[1], 6'd4);
        check("dual_instret", instret, CNT_EN ? 64'd2 : 64'd0);

        // Same destination on both lanes
        drive(lane(1, 7, 50, 32'h18, 0, 1, 0, 0), lane(1, 7, 51, 32'h1C, 0, 1, 0, 0), 1'b1);
        check("same_rrat7", rrat[7], 6'd51);
        check("same_free0", free_phys[0], 6'd7);
        check("same_free1", free_phys[1], 6'd50);

        // Taken mispredict on lane 0 discards lane 1
        drive(lane(1, 0, 0, 32'h100, 1, 0, 1, 13'h1FF0), lane(1, 9, 60, 32'h104, 0, 1, 0, 0), 1'b1);
        check("mp_redirect_valid", redirect_valid, 1'b1);
        check("mp_redirect_pc", redirect_pc, 32'hF0);
        check("mp_rrat9", rrat[9], 6'd9);
        check("mp_free_valid", free_valid, 2'b01);
        check("mp_free0", free_phys[0], 6'd60);
        check("mp_instret", instret, CNT_EN ? 64'd5 : 64'd0);

        // Not-taken mispredict with x0 destination
        drive(lane(1, 0, 33, 32'h200, 1, 0, 0, 13'h0040), lane(0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        check("nt_redirect_pc", redirect_pc, 32'h204);
        check("nt_free_valid", free_valid, 2'b00);
        idle(1'b1);
        check("pulse_one_cycle", redirect_valid, 1'b0);

        // Back-to-back mispredicts: lane 1 then lane 0
        drive(lane(1, 10, 12, 32'h3FC, 0, 1, 0, 0), lane(1, 0, 0, 32'h400, 1, 0, 1, 13'h0020), 1'b1);
        check("b2b_pc1", redirect_pc, 32'h420);
        drive(lane(1, 0, 0, 32'h1000, 1, 0, 0, 0), lane(0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        check("b2b_valid2", redirect_valid, 1'b1);
        check("b2b_pc2", redirect_pc, 32'h1004);
        idle(1'b1);
        idle(1'b1);
        check("drained_before_bp", free_valid, 2'b00);

        // Backpressure: 40 single pushes held, then overfill past 64
        for (int i = 0; i < 40; i++) begin
            drive(lane(1, (i % 30) + 1, $urandom_range(0, 63), 32'h2000, 0, 1, 0, 0),
                  lane(1, 0, $urandom_range(0, 63), 32'h2004, 0, 1, 0, 0), 1'b0);
            if (i == 0) first_freed = m_free[0];
            check("bp_hold", free_phys[0], first_freed);
        end
        check("bp_no_overflow", free_q_overflow, 1'b0);
        for (int j = 0; j < 13; j++)
            drive(lane(1, j + 1, $urandom_range(0, 63), 32'h3000, 0, 1, 0, 0),
                  lane(1, j + 14, $urandom_range(0, 63), 32'h3004, 0, 1, 0, 0), 1'b0);
        check("bp_overflow", free_q_overflow, 1'b1);
        check("bp_hold_after", free_phys[0], first_freed);

        // Reset mid-operation with a pulse pending and a full queue
        drive(lane(1, 9, 22, 32'h4000, 1, 0, 1, 13'h0008), lane(1, 5, 23, 32'h4004, 0, 1, 0, 0), 1'b0);
        check("pre_reset_pulse", redirect_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_reset_free_valid", free_valid, 2'b00);
        check("mid_reset_redirect", redirect_valid, 1'b0);
        check("mid_reset_overflow", free_q_overflow, 1'b0);
        check("mid_reset_rrat", rrat, pack_rrat());
        check("mid_reset_instret", instret, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random traffic, mostly-ready then mostly-stalled consumer
        for (int i = 0; i < 1500; i++)
            drive(rand_lane(), rand_lane(), $urandom_range(0, 3) != 0);
        for (int i = 0; i < 400; i++)
            drive(rand_lane(), rand_lane(), $urandom_range(0, 3) == 0);
        for (int i = 0; i < 40; i++) idle(1'b1);
        check("final_drained", free_valid, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
